// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
//
// Purpose:
//   Shares the board's six seven-segment digits (HEX0..HEX5) between two
//   writers: the CPU MMIO port (cpu) and the debug port (dbg). The block
//   holds NUM_PAGES 24-bit display pages and shows one page at a time. The
//   page comes either from timed auto rotation or from the switch-driven
//   page_sel input. While freeze is high, the shown value is held and the
//   digits blink.
//
// Ports:
//   clk          system clock (MAX10_CLK1_50 domain)
//   rst_n        asynchronous active-low reset
//   cpu_valid    cpu write request (held until granted)
//   cpu_ready    cpu write granted this cycle (combinational)
//   cpu_page     target page of the cpu write
//   cpu_data     six nibbles, [3:0] = HEX0
//   dbg_valid    dbg write request (held until granted)
//   dbg_ready    dbg write granted this cycle (combinational)
//   dbg_page     target page of the dbg write
//   dbg_data     six nibbles, [3:0] = HEX0
//   auto_rotate  1 = timed rotation, 0 = manual page_sel
//   page_sel     manual page index
//   freeze       hold the displayed value and blink the digits
//   hex_num      nibbles to the HexDriver instances, [4k+3:4k] = HEXk
//   digit_en     per-digit enable, 0 = blank
//   cur_page     index of the displayed page
//
// Parameters:
//   NUM_PAGES     2..4 pages, addressed by a 2-bit index
//   DWELL_CYCLES  cycles each page is shown in auto mode (>= 2)
//   BLINK_CYCLES  half-period of the freeze blink on digit_en (>= 1)

module hex_display_ctrl #(
    parameter int NUM_PAGES    = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [1:0]  cpu_page,
    input  logic [23:0] cpu_data,

    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [1:0]  dbg_page,
    input  logic [23:0] dbg_data,

    input  logic        auto_rotate,
    input  logic [1:0]  page_sel,
    input  logic        freeze,

    output logic [23:0] hex_num,
    output logic [5:0]  digit_en,
    output logic [1:0]  cur_page
);

    // Round-robin memory: which requester was granted most recently.
    localparam logic [0:0] GRANT_CPU = 1'b0;
    localparam logic [0:0] GRANT_DBG = 1'b1;

    localparam int unsigned NP      = NUM_PAGES;
    localparam int          DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int          BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [1:0]         LAST_PAGE  = 2'(NUM_PAGES - 1);

    localparam logic [5:0] DIGITS_ON = 6'h3F;

    logic [0:0]         last_grant;
    logic               wr_en;
    logic [1:0]         wr_page;
    logic [23:0]        wr_data;
    logic [23:0]        page_reg [NUM_PAGES];
    logic [23:0]        disp_word;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [BLINK_W-1:0] blink_cnt;

    // True when a 2-bit page index addresses an existing page.
    function automatic logic page_exists(input logic [1:0] p);
        return ({30'd0, p} < NP);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // A lone requester always wins. On a tie, the side that was not granted
    // last wins. Each ready is qualified by its own valid, so ready never
    // rises on an idle port.
    assign cpu_ready = cpu_valid & (~dbg_valid | (last_grant == GRANT_DBG));
    assign dbg_ready = dbg_valid & (~cpu_valid | (last_grant == GRANT_CPU));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_DBG;
        end else if (cpu_ready) begin
            last_grant <= GRANT_CPU;
        end else if (dbg_ready) begin
            last_grant <= GRANT_DBG;
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    always_comb begin
        wr_en   = 1'b0;
        wr_page = cpu_page;
        wr_data = cpu_data;
        if (cpu_ready) begin
            wr_en = 1'b1;
        end else if (dbg_ready) begin
            wr_en   = 1'b1;
            wr_page = dbg_page;
            wr_data = dbg_data;
        end
    end

    // Writes to a page index beyond NUM_PAGES are handshaken as normal, but
    // no register matches the index, so the data is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NP; i++) begin
                page_reg[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NP; i++) begin
                if (wr_page == 2'(i)) begin
                    page_reg[i] <= wr_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display path
    // ------------------------------------------------------------------
    always_comb begin
        disp_word = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (cur_page == 2'(i)) begin
                disp_word = page_reg[i];
            end
        end
    end

    // Registered from page_reg, so a write at edge N is shown at edge N+1.
    // freeze only stops this load; writes are still accepted underneath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_num <= '0;
        end else if (!freeze) begin
            hex_num <= disp_word;
        end
    end

    // ------------------------------------------------------------------
    // Page sequencing
    // ------------------------------------------------------------------
    // Manual mode keeps the dwell counter at 0. When auto mode is entered,
    // the rotation therefore starts a full dwell period from the current
    // page.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            cur_page  <= '0;
        end else if (!auto_rotate) begin
            dwell_cnt <= '0;
            if (page_exists(page_sel)) begin
                cur_page <= page_sel;
            end
        end else if (!freeze) begin
            if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt <= '0;
                cur_page  <= (cur_page == LAST_PAGE) ? 2'd0 : cur_page + 2'd1;
            end else begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Freeze blink
    // ------------------------------------------------------------------
    // The counter starts from 0 on each freeze, so the first blank comes
    // BLINK_CYCLES edges after freeze rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            digit_en  <= DIGITS_ON;
        end else if (!freeze) begin
            blink_cnt <= '0;
            digit_en  <= DIGITS_ON;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            digit_en  <= ~digit_en;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

endmodule
